// File: rtl/oversampled_tx.sv
// Oversampled serial transmitter: one bit per clock, MSB first, spread over an 8-sample word with a latched bit-boundary phase.
// Optional PRBS7 source when OVERSAMPLED_TX_PRBS_EN is defined.
module oversampled_tx #(
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       enable,
  input  logic       din_valid,
  input  logic [7:0] din_data,
  output logic       din_ready,
  input  logic [2:0] phase,
  input  logic       prbs_mode,
  output logic [7:0] samples,
  output logic [7:0] o_edge,
  output logic       busy
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SEND = 1'b1;

  logic       r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shifter;
  logic       r_prev;
  logic [2:0] r_phase_cur;
  logic [7:0] r_samples;
  logic [7:0] r_edge;

  logic       w_prbs_on;
  logic       w_prbs_rise;
  logic       w_prbs_exit;
  logic       w_prbs_bit;
  logic       w_accept;
  logic       w_cur;
  logic [2:0] w_ph;
  logic [2:0] w_cnt;
  logic [7:0] w_samples;
  logic [7:0] w_edge;

`ifdef OVERSAMPLED_TX_PRBS_EN
  logic       r_prbs_d;
  logic [6:0] r_lfsr;
  logic [6:0] w_lfsr_src;

  // The seed is substituted on the rising edge so the first PRBS bit comes from 7'h7F.
  always_comb begin
    w_prbs_on   = prbs_mode;
    w_prbs_rise = prbs_mode & ~r_prbs_d;
    w_prbs_exit = ~prbs_mode & r_prbs_d;
    w_lfsr_src  = w_prbs_rise ? 7'h7F : r_lfsr;
    w_prbs_bit  = w_lfsr_src[6] ^ w_lfsr_src[5];
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      r_prbs_d <= 1'b0;
      r_lfsr   <= 7'h7F;
    end else if (enable) begin
      r_prbs_d <= prbs_mode;
      if (w_prbs_on) r_lfsr <= {w_lfsr_src[5:0], w_prbs_bit};
    end
  end
`else
  logic w_unused_prbs;

  assign w_unused_prbs = prbs_mode;

  always_comb begin
    w_prbs_on   = 1'b0;
    w_prbs_rise = 1'b0;
    w_prbs_exit = 1'b0;
    w_prbs_bit  = 1'b0;
  end
`endif

  always_comb begin
    din_ready = enable & res_n & ~w_prbs_on &
                ((r_state == ST_IDLE) | (r_bit_cnt == 3'd7) | w_prbs_exit);
    w_accept  = din_valid & din_ready;
    w_cnt     = w_prbs_rise ? 3'd0 : r_bit_cnt;
    // PRBS relatches the boundary at every byte start; data mode only on acceptance.
    w_ph      = (w_prbs_on & (w_cnt == 3'd0)) ? phase : r_phase_cur;
    if (w_prbs_on)
      w_cur = w_prbs_bit;
    else if ((r_state == ST_SEND) && !w_prbs_exit)
      w_cur = r_shifter[3'd7 - r_bit_cnt];
    else
      w_cur = IDLE_LEVEL;
    w_samples = '0;
    for (int unsigned i = 0; i < 8; i++)
      w_samples[i] = (i < {29'd0, w_ph}) ? r_prev : w_cur;
    w_edge = (w_cur != r_prev) ? (8'h01 << w_ph) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shifter   <= '0;
      r_prev      <= IDLE_LEVEL;
      r_phase_cur <= '0;
      r_samples   <= {8{IDLE_LEVEL}};
      r_edge      <= '0;
    end else if (enable) begin
      r_samples <= w_samples;
      r_edge    <= w_edge;
      r_prev    <= w_cur;
      if (w_accept) begin
        r_shifter   <= din_data;
        r_bit_cnt   <= '0;
        r_phase_cur <= phase;
        r_state     <= ST_SEND;
      end else if (w_prbs_on) begin
        r_state     <= ST_SEND;
        r_bit_cnt   <= w_cnt + 3'd1;
        r_phase_cur <= w_ph;
      end else if ((r_state == ST_SEND) && !w_prbs_exit) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) r_state <= ST_IDLE;
      end else begin
        r_state   <= ST_IDLE;
        r_bit_cnt <= '0;
      end
    end
  end

  assign samples = r_samples;
  assign o_edge  = r_edge;
  assign busy    = (r_state == ST_SEND);

endmodule
